// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared state encoding and defaults for the bus ownership stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_OWNED   = 2'd1;
  localparam logic [1:0] STATE_RELEASE = 2'd2;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage : bus_arbiter_pkg

`default_nettype wire

// File: rtl/GenericArbiter.sv
// ============================================================================
// Module      : GenericArbiter
// Description : Combinational fixed-priority arbiter, bit 0 highest priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module GenericArbiter #(
  parameter int width = 8
) (
  input  logic [width-1:0] request,
  output logic [width-1:0] grant
);

  // Isolate the lowest set bit.
  assign grant = request & (~request + {{(width-1){1'b0}}, 1'b1});

endmodule : GenericArbiter

`default_nettype wire

// File: rtl/bus_ownership_arbiter.sv
// ============================================================================
// Module      : bus_ownership_arbiter
// Description : Registered bus ownership with release turnaround and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_ownership_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int width         = 8,
  parameter int indexWidth    = 3,
  parameter int timeoutCycles = DEFAULT_TIMEOUT_CYCLES,
  parameter int counterWidth  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [width-1:0]      request,
  input  logic                  ack,
  output logic [width-1:0]      grant,
  output logic [indexWidth-1:0] ownerIndex,
  output logic                  busy,
  output logic                  timeoutError,
  output logic [width-1:0]      lockMask
);

  localparam bit                    c_WATCHDOG_EN = (timeoutCycles != 0);
  localparam logic [counterWidth-1:0] c_LAST_COUNT = counterWidth'(timeoutCycles - 1);

  logic [1:0]              r_state;
  logic [width-1:0]        r_grant;
  logic [indexWidth-1:0]   r_ownerIndex;
  logic                    r_busy;
  logic                    r_timeoutError;
  logic [width-1:0]        r_lockMask;
  logic [counterWidth-1:0] r_counter;

  logic [width-1:0]        w_arbRequest;
  logic [width-1:0]        w_arbGrant;

  function automatic logic [indexWidth-1:0] f_encode(input logic [width-1:0] onehot);
    logic [indexWidth-1:0] idx;
    idx = '0;
    for (int i = 0; i < width; i++) begin
      if (onehot[i]) idx = idx | indexWidth'(i);
    end
    return idx;
  endfunction

  assign w_arbRequest = request & ~r_lockMask;

  GenericArbiter #(
    .width(width)
  ) u_arbiter (
    .request(w_arbRequest),
    .grant  (w_arbGrant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= STATE_IDLE;
      r_grant        <= '0;
      r_ownerIndex   <= '0;
      r_busy         <= 1'b0;
      r_timeoutError <= 1'b0;
      r_lockMask     <= '0;
      r_counter      <= '0;
    end else begin
      r_timeoutError <= 1'b0;
      // Locks release whenever the locked master lets go of its request.
      r_lockMask     <= r_lockMask & request;
      case (r_state)
        STATE_IDLE: begin
          if (w_arbGrant != '0) begin
            r_grant      <= w_arbGrant;
            r_ownerIndex <= f_encode(w_arbGrant);
            r_busy       <= 1'b1;
            r_counter    <= '0;
            r_state      <= STATE_OWNED;
          end
        end
        STATE_OWNED: begin
          if (!request[r_ownerIndex]) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= STATE_RELEASE;
          end else if (ack) begin
            r_counter <= '0;
          end else if (c_WATCHDOG_EN && (r_counter == c_LAST_COUNT)) begin
            // r_grant is the owner's one-hot bit, so it doubles as the lock bit.
            r_lockMask     <= (r_lockMask & request) | r_grant;
            r_grant        <= '0;
            r_busy         <= 1'b0;
            r_timeoutError <= 1'b1;
            r_state        <= STATE_RELEASE;
          end else if (r_counter != '1) begin
            r_counter <= r_counter + 1'b1;
          end
        end
        STATE_RELEASE: begin
          r_state <= STATE_IDLE;
        end
        default: begin
          r_state <= STATE_IDLE;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign ownerIndex   = r_ownerIndex;
  assign busy         = r_busy;
  assign timeoutError = r_timeoutError;
  assign lockMask     = r_lockMask;

endmodule : bus_ownership_arbiter

`default_nettype wire

// File: tb/tb_bus_ownership_arbiter.sv
// ============================================================================
// Module      : tb_bus_ownership_arbiter
// Description : Directed vector bench for bus_ownership_arbiter (timeout = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_ownership_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] request;
  logic       ack;
  logic [7:0] grant;
  logic [2:0] ownerIndex;
  logic       busy;
  logic       timeoutError;
  logic [7:0] lockMask;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic [7:0] grant;
    logic       busy;
    logic [2:0] owner;
    logic       to;
    logic [7:0] lock;
  } vec_t;

  vec_t vecs[$];

  bus_ownership_arbiter #(
    .width        (8),
    .indexWidth   (3),
    .timeoutCycles(4),
    .counterWidth (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .ack         (ack),
    .grant       (grant),
    .ownerIndex  (ownerIndex),
    .busy        (busy),
    .timeoutError(timeoutError),
    .lockMask    (lockMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] r, input logic a, input logic [7:0] g, input logic b,
                     input logic [2:0] o, input logic t, input logic [7:0] l);
    vec_t v;
    v.req = r; v.ack = a; v.grant = g; v.busy = b; v.owner = o; v.to = t; v.lock = l;
    vecs.push_back(v);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; request = 8'hFF; ack = 1'b0;

    // Reset with all masters requesting.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_grant", grant, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_lock", lockMask, 8'h00);
      check("rst_to", timeoutError, 1'b0);
    end
    reset = 1'b0; request = 8'h00;
    tick();

    //   req    ack  grant  busy owner to lock
    add(8'h06, 0, 8'h02, 1, 3'd1, 0, 8'h00);  // lowest requester wins
    add(8'h07, 0, 8'h02, 1, 3'd1, 0, 8'h00);  // no preemption
    add(8'h07, 1, 8'h02, 1, 3'd1, 0, 8'h00);
    add(8'h05, 0, 8'h00, 0, 3'd0, 0, 8'h00);  // owner drops -> RELEASE
    add(8'h05, 0, 8'h00, 0, 3'd0, 0, 8'h00);  // IDLE
    add(8'h05, 0, 8'h01, 1, 3'd0, 0, 8'h00);  // new grant at n+2
    add(8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    add(8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    add(8'h04, 0, 8'h04, 1, 3'd2, 0, 8'h00);  // owner 2, counter 0
    add(8'h24, 0, 8'h04, 1, 3'd2, 0, 8'h00);  // counter 1
    add(8'h24, 0, 8'h04, 1, 3'd2, 0, 8'h00);  // counter 2
    add(8'h24, 0, 8'h04, 1, 3'd2, 0, 8'h00);  // counter 3
    add(8'h24, 0, 8'h00, 0, 3'd0, 1, 8'h04);  // 4th owned edge: revoke
    add(8'h24, 0, 8'h00, 0, 3'd0, 0, 8'h04);  // pulse is one cycle
    add(8'h24, 0, 8'h20, 1, 3'd5, 0, 8'h04);  // locked master skipped
    add(8'h20, 0, 8'h20, 1, 3'd5, 0, 8'h00);  // master 2 releases -> unlock
    add(8'h24, 1, 8'h20, 1, 3'd5, 0, 8'h00);
    add(8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    add(8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    add(8'h04, 0, 8'h04, 1, 3'd2, 0, 8'h00);  // master 2 re-granted
    add(8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    add(8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h00);
    add(8'h08, 0, 8'h08, 1, 3'd3, 0, 8'h00);
    add(8'h08, 0, 8'h08, 1, 3'd3, 0, 8'h00);
    add(8'h08, 0, 8'h08, 1, 3'd3, 0, 8'h00);
    add(8'h08, 0, 8'h08, 1, 3'd3, 0, 8'h00);  // counter now 3
    add(8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h00);  // drop wins over timeout
    add(8'h00, 1, 8'h00, 0, 3'd0, 0, 8'h00);  // ack ignored outside OWNED

    foreach (vecs[i]) begin
      request = vecs[i].req;
      ack     = vecs[i].ack;
      tick();
      check($sformatf("v%0d_grant", i), grant, vecs[i].grant);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].busy) check($sformatf("v%0d_owner", i), ownerIndex, vecs[i].owner);
      check($sformatf("v%0d_to", i), timeoutError, vecs[i].to);
      check($sformatf("v%0d_lock", i), lockMask, vecs[i].lock);
    end

    // Periodic ack keeps the owner alive well past the timeout.
    request = 8'h04; ack = 1'b0;
    tick();
    check("ackseq_grant0", grant, 8'h04);
    for (int i = 0; i < 50; i++) begin
      ack = (i % 3 == 2);
      tick();
      check("ackseq_grant", grant, 8'h04);
      check("ackseq_to", timeoutError, 1'b0);
    end

    // Withhold ack: revocation must arrive within a bounded window.
    ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (timeoutError) seen = 1'b1;
    end
    check("wd_seen", seen, 1'b1);
    check("wd_lock", lockMask, 8'h04);
    check("wd_grant", grant, 8'h00);

    // Reset mid-ownership clears the lock and ownership.
    request = 8'h06;
    tick(); tick();
    check("pre_rst_grant", grant, 8'h02);
    reset = 1'b1;
    tick();
    check("midrst_grant", grant, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_lock", lockMask, 8'h00);
    reset = 1'b0;
    tick();
    check("postrst_grant", grant, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bus_ownership_arbiter

`default_nettype wire

// File: doc/bus_ownership_arbiter.md
Name: bus_ownership_arbiter

Overview:
Registered multi-master bus ownership stage placed directly downstream of GenericArbiter.
- Feeds the masked request vector into one GenericArbiter instance.
- Latches the one-hot winner as the bus owner and holds it until the owner drops its request.
- Runs a no-ack watchdog that revokes a hung owner and masks it out until it releases.

Parameters:
width, 8, number of masters (request/grant bits); bit 0 has highest priority
indexWidth, 3, width of encoded owner index; must be >= clog2(width)
timeoutCycles, 255, consecutive owned cycles without ack before revocation; 0 disables watchdog
counterWidth, 8, watchdog counter width; must hold timeoutCycles

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
request  input  width  per-master bus request, level, held for whole transaction
ack  input  1  slave acknowledge for the current owner's cycle
grant  output  width  registered one-hot owner, all-zero when bus idle
ownerIndex  output  indexWidth  binary index of grant bit; valid only while busy
busy  output  1  registered, 1 iff grant != 0
timeoutError  output  1  single-cycle pulse on watchdog revocation
lockMask  output  width  masters currently locked out after timeout

Behaviour:
- Reset values: state IDLE, grant=0, ownerIndex=0, busy=0, timeoutError=0, lockMask=0, counter=0. Reset wins over all events, including mid-ownership.
- Arbiter input is request & ~lockMask. GenericArbiter is combinational; its output is used only in IDLE.
- States: IDLE, OWNED, RELEASE. Encoding is 2 bits.
- IDLE:
  - If arbiter output != 0: grant<=output, ownerIndex<=encode(output), busy<=1, counter<=0, go OWNED.
  - Else stay IDLE.
  - Latency: request seen at edge k gives grant visible after edge k.
- OWNED: evaluated each edge in priority order.
  - (a) request[ownerIndex]==0: grant<=0, busy<=0, go RELEASE. No error is raised, even if the timeout coincides.
  - (b) ack==1: counter<=0, stay OWNED.
  - (c) timeoutCycles!=0 and counter==timeoutCycles-1: grant<=0, busy<=0, lockMask[ownerIndex]<=1, timeoutError<=1 for one cycle, go RELEASE.
  - (d) Else counter<=counter+1. Counter saturates and never wraps.
- RELEASE: one mandatory bus turnaround cycle with grant=0. Always go to IDLE.
  - Minimum gap between owners: owner drop at edge n gives grant=0 after n, IDLE after n+1, new grant after n+2.
- lockMask:
  - Each bit clears on any edge where the corresponding request bit is 0.
  - A set and a clear of the same bit on the same edge: set wins. This cannot occur, because a set requires the request to be high.
- Requests of non-owners never disturb the current ownership. Priority is rechecked only in IDLE; no preemption.
- ack outside OWNED is ignored. Request changes during RELEASE are ignored until IDLE.
- timeoutError is 0 in every cycle except the one following a revocation edge.

Decomposition:
- Shared package bus_arbiter_pkg:
  - State encoding constants STATE_IDLE=0, STATE_OWNED=1, STATE_RELEASE=2.
  - Default timeout constant.
- Sub-module: the existing GenericArbiter (width=width), instantiated once for priority selection.
- One-hot-to-index encoder is an internal function, not a separate module.

Test Plan:
- Reset held 2 cycles with request=8'hFF -> grant=0, busy=0, lockMask=0, timeoutError=0 throughout reset.
- request=8'b00000110 from idle -> after 1 edge grant=8'b00000010, ownerIndex=1, busy=1. Raise request[0] while owned -> grant unchanged.
- Owner 1 drops request at edge n with request[0] high -> grant=0 after n and n+1, grant=8'b00000001 after n+2.
- timeoutCycles=4, owner 2 requests with no ack -> revocation on 4th owned edge: timeoutError=1 one cycle, lockMask=8'b00000100. Master 5 requesting gets grant 8'b00100000 two edges later.
- Same setup with ack pulsed every 3 cycles -> no timeout for 50 cycles. Counter resets on each ack.
- Locked master 2 drops request for one cycle -> lockMask=0. It is re-granted normally on the next IDLE.
